// File: rtl/mmio_pkg.sv
// Shared definitions for the data-side memory / MMIO responder:
// default map addresses, run-status encoding, region decode and lane merge.
package mmio_pkg;

    localparam int unsigned DEPTH_WORDS_DEF    = 256;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 250;
    localparam logic [31:0] LED_ADDR_DEF       = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE_ADDR_DEF     = 32'hFFFF_0004;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        RGN_RAM   = 2'd0,
        RGN_LED   = 2'd1,
        RGN_CYCLE = 2'd2,
        RGN_NONE  = 2'd3
    } region_t;

    // Replace the byte lanes of old_word selected by strb with those of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_strobe_ram.sv
// Word-organised RAM with asynchronous read and byte-strobed synchronous write.
// Contents are intentionally not reset so they survive a core reset.
module byte_strobe_ram #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     strb,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_mmio.sv
// Data-port responder: byte-strobed RAM, LED/result register, cycle counter,
// sticky bus error and a run-status FSM that turns the LED write into PASS/FAIL.
module data_mem_mmio
    import mmio_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = DEPTH_WORDS_DEF,
    parameter logic [31:0] LED_ADDR       = LED_ADDR_DEF,
    parameter logic [31:0] CYCLE_ADDR     = CYCLE_ADDR_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [3:0]  Strobe,
    output logic [31:0] RD,
    output logic [31:0] led,
    output logic [31:0] cycle_cnt,
    output logic [1:0]  status,
    output logic        done,
    output logic        bus_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    region_t     region_c;
    logic        ram_we_c;
    logic [31:0] ram_rd_c;
    logic        any_strb_c;
    logic        led_wr_c;
    logic [31:0] led_merged_c;

    status_t     state_q, state_d;
    logic [31:0] led_q, led_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        done_q, done_d;
    logic        bus_err_q, bus_err_d;

    // Address decode; the two low address bits never take part in MMIO matching.
    always_comb begin
        region_c = RGN_NONE;
        if (Addr < RAM_BYTES) begin
            region_c = RGN_RAM;
        end else if (Addr[31:2] == LED_ADDR[31:2]) begin
            region_c = RGN_LED;
        end else if (Addr[31:2] == CYCLE_ADDR[31:2]) begin
            region_c = RGN_CYCLE;
        end
    end

    assign ram_we_c = WE && (region_c == RGN_RAM);

    byte_strobe_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (Addr[AW+1:2]),
        .wdata (WD),
        .strb  (Strobe),
        .rdata (ram_rd_c)
    );

    always_comb begin
        RD = 32'd0;
        case (region_c)
            RGN_RAM:   RD = ram_rd_c;
            RGN_LED:   RD = led_q;
            RGN_CYCLE: RD = cycle_cnt_q;
            default:   RD = 32'd0;
        endcase
    end

    // A write with no lanes enabled carries no data, so it neither counts as a
    // result write nor as an unmapped access.
    assign any_strb_c   = |Strobe;
    assign led_wr_c     = WE && any_strb_c && (region_c == RGN_LED) && (state_q == ST_RUN);
    assign led_merged_c = merge_lanes(led_q, WD, Strobe);

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        cycle_cnt_d = cycle_cnt_q;
        bus_err_d   = bus_err_q;
        done_d      = done_q;

        case (state_q)
            ST_RUN: begin
                if (led_wr_c) begin
                    led_d   = led_merged_c;
                    state_d = (led_merged_c == 32'd1) ? ST_PASS : ST_FAIL;
                end else if (cycle_cnt_q == TO_LAST) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase

        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (WE && any_strb_c && (region_c == RGN_NONE)) bus_err_d = 1'b1;
        done_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            led_q       <= 32'd0;
            cycle_cnt_q <= 32'd0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign led       = led_q;
    assign cycle_cnt = cycle_cnt_q;
    assign status    = 2'(state_q);
    assign done      = done_q;
    assign bus_err   = bus_err_q;

endmodule
